// File: rtl/vga_rect_scheduler.sv
// Round-robin arbiter plus filled-rectangle rasteriser feeding the vga_adapter pixel port.
// Optional full-screen clear is built when VGA_RECT_CLEAR_EN is defined.
module vga_rect_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3,
  parameter int MAX_X   = 159,
  parameter int MAX_Y   = 119
`ifdef VGA_RECT_CLEAR_EN
  , parameter logic [C_W-1:0] CLEAR_COLOUR = '0
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
`ifdef VGA_RECT_CLEAR_EN
  input  logic                   clear_req,
`endif
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  input  logic [NUM_REQ*X_W-1:0] req_w,
  input  logic [NUM_REQ*Y_W-1:0] req_h,
  input  logic [NUM_REQ*C_W-1:0] req_colour,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             done_id
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [X_W:0]   MAX_X_L = (X_W+1)'(MAX_X);
  localparam logic [Y_W:0]   MAX_Y_L = (Y_W+1)'(MAX_Y);
  localparam logic [X_W-1:0] X_ONE   = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       last_grant_q, last_grant_d, id_q, id_d, done_id_q, done_id_d;
  logic [X_W-1:0]   x0_q, x0_d, w_q, w_d, col_q, col_d, x_q, x_d;
  logic [Y_W-1:0]   y0_q, y0_d, h_q, h_d, row_q, row_d, y_q, y_d;
  logic [C_W-1:0]   colr_q, colr_d, colour_q, colour_d;
  logic             plot_q, plot_d, done_q, done_d;

  logic [1:0]       grant;
  logic             found, accept, last_px, clear_hit;
  logic [X_W-1:0]   sel_x, sel_w;
  logic [Y_W-1:0]   sel_y, sel_h;
  logic [C_W-1:0]   sel_c;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;

  // Round-robin search from last_grant+1; payload is captured from the winner.
  // Handshake: a command transfers on the edge where req_valid[i] & req_ready[i];
  // ready is only offered in IDLE, to the single winner, and may depend on valid.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sel_x = '0;
    sel_y = '0;
    sel_w = '0;
    sel_h = '0;
    sel_c = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && ((int'(last_grant_q) + k) % NUM_REQ == i)) begin
          found = 1'b1;
          grant = 2'(i);
          sel_x = req_x[i*X_W +: X_W];
          sel_y = req_y[i*Y_W +: Y_W];
          sel_w = req_w[i*X_W +: X_W];
          sel_h = req_h[i*Y_W +: Y_W];
          sel_c = req_colour[i*C_W +: C_W];
        end
      end
    end
`ifdef VGA_RECT_CLEAR_EN
    clear_hit = (state_q == S_IDLE) && clear_req;
`else
    clear_hit = 1'b0;
`endif
    accept  = (state_q == S_IDLE) && found && !clear_hit;
    last_px = (col_q == w_q - X_ONE) && (row_q == h_q - Y_ONE);
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant == 2'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 2'(NUM_REQ - 1);
      id_q         <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      colr_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      w_q          <= w_d;
      h_q          <= h_d;
      col_q        <= col_d;
      row_q        <= row_d;
      colr_q       <= colr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (clear_hit) state_d = S_DRAW;
        else if (accept) state_d = (sel_w == '0 || sel_h == '0) ? S_DONE : S_DRAW;
      end
      S_DRAW:  if (last_px) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel outputs are registered from the counters of the cycle being entered,
  // so the first pixel appears the cycle after the accept edge.
  always_comb begin
    last_grant_d = last_grant_q;
    id_d         = id_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    col_d        = col_q;
    row_d        = row_q;
    colr_d       = colr_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    if (clear_hit) begin
`ifdef VGA_RECT_CLEAR_EN
      x0_d   = '0;
      y0_d   = '0;
      w_d    = X_W'(MAX_X + 1);
      h_d    = Y_W'(MAX_Y + 1);
      colr_d = CLEAR_COLOUR;
      id_d   = '0;
      col_d  = '0;
      row_d  = '0;
`endif
    end else if (accept) begin
      x0_d         = sel_x;
      y0_d         = sel_y;
      w_d          = sel_w;
      h_d          = sel_h;
      colr_d       = sel_c;
      id_d         = grant;
      last_grant_d = grant;
      col_d        = '0;
      row_d        = '0;
    end else if (state_q == S_DRAW && !last_px) begin
      if (col_q == w_q - X_ONE) begin
        col_d = '0;
        row_d = row_q + Y_ONE;
      end else begin
        col_d = col_q + X_ONE;
      end
    end
    // One extra bit keeps off-screen pixels from wrapping onto column/row 0.
    sum_x = {1'b0, x0_d} + {1'b0, col_d};
    sum_y = {1'b0, y0_d} + {1'b0, row_d};
    if (state_d == S_DRAW) begin
      x_d      = sum_x[X_W-1:0];
      y_d      = sum_y[Y_W-1:0];
      colour_d = colr_d;
      plot_d   = (sum_x <= MAX_X_L) && (sum_y <= MAX_Y_L);
    end
    if (state_d == S_DONE) begin
      done_d    = 1'b1;
      done_id_d = id_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_vga_rect_scheduler.sv
// Directed bench for vga_rect_scheduler: command table plus hand sequences for
// reset, round-robin, zero-size, clipping, mid-draw reset and optional clear.
module tb_vga_rect_scheduler;
  localparam int NUM_REQ = 2;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  logic                   clock;
  logic                   reset;
  logic                   clear_req;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*X_W-1:0] req_x, req_w;
  logic [NUM_REQ*Y_W-1:0] req_y, req_h;
  logic [NUM_REQ*C_W-1:0] req_colour;
  logic [X_W-1:0]         x;
  logic [Y_W-1:0]         y;
  logic [C_W-1:0]         colour;
  logic                   plot, busy, done;
  logic [1:0]             done_id;

  int checks = 0;
  int errors = 0;

  vga_rect_scheduler #(.NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
    .clock(clock),
    .reset(reset),
`ifdef VGA_RECT_CLEAR_EN
    .clear_req(clear_req),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x(req_x),
    .req_y(req_y),
    .req_w(req_w),
    .req_h(req_h),
    .req_colour(req_colour),
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .busy(busy),
    .done(done),
    .done_id(done_id)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // driver
  task automatic set_cmd(input int id, input int cx, input int cy, input int cw, input int ch, input int cc);
    req_x[id*X_W +: X_W]      = X_W'(cx);
    req_y[id*Y_W +: Y_W]      = Y_W'(cy);
    req_w[id*X_W +: X_W]      = X_W'(cw);
    req_h[id*Y_W +: Y_W]      = Y_W'(ch);
    req_colour[id*C_W +: C_W] = C_W'(cc);
  endtask

  // Raise valid for id and hold until the accept edge has passed.
  task automatic wait_accept(input int id, output int accepted);
    req_valid[id] = 1'b1;
    #1;
    accepted = 0;
    for (int t = 0; t < 60 && accepted == 0; t++) begin
      if (req_ready[id]) accepted = 1;
      tick();
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int t = 0; t < 500 && busy; t++) tick();
    check(name, int'(busy), 0);
  endtask

  task automatic run_cmd(input int id, input int cx, input int cy, input int cw, input int ch,
                         input int cc, output int accepted, output int plots, output int lx,
                         output int ly, output int lat, output int did, output int cbad);
    set_cmd(id, cx, cy, cw, ch, cc);
    wait_accept(id, accepted);
    plots = 0; lx = -1; ly = -1; lat = -1; did = -1; cbad = 0;
    if (accepted != 0) begin
      for (int k = 1; k <= 300; k++) begin
        if (plot) begin
          plots++;
          lx = int'(x);
          ly = int'(y);
          if (int'(colour) != cc) cbad++;
        end
        if (done) begin
          lat = k;
          did = int'(done_id);
          break;
        end
        tick();
      end
    end
  endtask

  typedef struct {
    int id, cx, cy, cw, ch, cc;
    int e_plots, e_lx, e_ly, e_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int acc, plots, lx, ly, lat, did, cbad;
    int ex[4];
    int gr[4];
    int gt[4];
    int ng;
    int pc;
    int done_seen;

    vecs[0] = '{0, 10,   5, 2, 2, 3,  4,  11,  6,  5};
    vecs[1] = '{1, 158,  0, 4, 1, 5,  2, 159,  0,  5};
    vecs[2] = '{0, 0,  118, 3, 3, 7,  6,   2, 119, 10};
    vecs[3] = '{1, 157, 117, 5, 5, 1, 9, 159, 119, 26};
    vecs[4] = '{0, 4,    4, 0, 7, 6,  0,  -1, -1,  1};
    vecs[5] = '{1, 20,  30, 1, 1, 2,  1,  20, 30,  2};
    vecs[6] = '{0, 255, 127, 1, 1, 4, 0,  -1, -1,  2};
    vecs[7] = '{1, 3,    3, 3, 0, 1,  0,  -1, -1,  1};

    reset = 1'b0;
    clear_req = 1'b0;
    req_valid = '0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    #1;
    tick();
    tick();
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_done_id", int'(done_id), 0);
    check("rst_xy", int'(x) + int'(y) + int'(colour), 0);
    check("rst_ready", int'(req_ready), 0);
    reset = 1'b1;
    tick();

    // single 2x2 rectangle, pixel by pixel
    ex = '{10, 11, 10, 11};
    set_cmd(0, 10, 5, 2, 2, 3);
    wait_accept(0, acc);
    check("s_accept", acc, 1);
    for (int p = 0; p < 4; p++) begin
      check("s_plot", int'(plot), 1);
      check("s_x", int'(x), ex[p]);
      check("s_y", int'(y), 5 + p / 2);
      check("s_colour", int'(colour), 3);
      check("s_busy", int'(busy), 1);
      tick();
    end
    check("s_done", int'(done), 1);
    check("s_done_id", int'(done_id), 0);
    check("s_done_plot", int'(plot), 0);
    tick();
    check("s_busy_low", int'(busy), 0);
    check("s_done_pulse", int'(done), 0);

    // zero-size: done next cycle, re-accept two cycles after accept
    set_cmd(0, 7, 7, 0, 7, 2);
    req_valid[0] = 1'b1;
    #1;
    acc = 0;
    for (int t = 0; t < 20 && acc == 0; t++) begin
      if (req_ready[0]) acc = 1;
      tick();
    end
    check("z_accept", acc, 1);
    check("z_done", int'(done), 1);
    check("z_plot", int'(plot), 0);
    check("z_ready_n1", int'(req_ready), 0);
    tick();
    check("z_ready_n2", int'(req_ready), 1);
    check("z_busy_n2", int'(busy), 0);
    req_valid = '0;
    tick();

    // round-robin with both requesters continuously valid
    do_reset();
    set_cmd(0, 1, 1, 1, 1, 1);
    set_cmd(1, 2, 2, 1, 1, 2);
    req_valid = 2'b11;
    #1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      if (req_ready != '0) begin
        check("rr_onehot", $countones(req_ready), 1);
        gr[ng] = req_ready[1] ? 1 : 0;
        gt[ng] = c;
        ng++;
      end
      tick();
    end
    req_valid = '0;
    check("rr_count", ng, 4);
    for (int i = 0; i < 4 && i < ng; i++) check("rr_order", gr[i], i % 2);
    for (int i = 1; i < 4 && i < ng; i++) check("rr_gap", gt[i] - gt[i-1], 3);
    wait_idle("rr_idle");

    // reset at pixel 37 of a 10x10 rectangle
    set_cmd(0, 50, 50, 10, 10, 6);
    wait_accept(0, acc);
    check("md_accept", acc, 1);
    pc = 0;
    for (int k = 0; k < 200; k++) begin
      if (plot) pc++;
      if (pc == 37) break;
      tick();
    end
    check("md_pix_count", pc, 37);
    check("md_px_x", int'(x), 56);
    check("md_px_y", int'(y), 53);
    reset = 1'b0;
    #1;
    check("md_plot_async", int'(plot), 0);
    check("md_busy_async", int'(busy), 0);
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (done) done_seen++;
      tick();
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (done) done_seen++;
      tick();
    end
    check("md_no_done", done_seen, 0);
    set_cmd(1, 9, 9, 1, 1, 1);
    req_valid = 2'b11;
    #1;
    check("md_prio0", int'(req_ready), 1);
    req_valid = '0;
    tick();
    wait_idle("md_idle");

    // command table
    for (int v = 0; v < 8; v++) begin
      run_cmd(vecs[v].id, vecs[v].cx, vecs[v].cy, vecs[v].cw, vecs[v].ch, vecs[v].cc,
              acc, plots, lx, ly, lat, did, cbad);
      check($sformatf("t%0d_accept", v), acc, 1);
      check($sformatf("t%0d_plots", v), plots, vecs[v].e_plots);
      check($sformatf("t%0d_last_x", v), lx, vecs[v].e_lx);
      check($sformatf("t%0d_last_y", v), ly, vecs[v].e_ly);
      check($sformatf("t%0d_latency", v), lat, vecs[v].e_lat);
      check($sformatf("t%0d_done_id", v), did, vecs[v].id);
      check($sformatf("t%0d_colour", v), cbad, 0);
      tick();
      check($sformatf("t%0d_busy_low", v), int'(busy), 0);
    end

`ifdef VGA_RECT_CLEAR_EN
    // clear has priority over a waiting requester and fills the whole screen
    do_reset();
    set_cmd(0, 5, 5, 1, 1, 7);
    req_valid[0] = 1'b1;
    clear_req = 1'b1;
    #1;
    check("clr_no_ready", int'(req_ready), 0);
    tick();
    clear_req = 1'b0;
    plots = 0; lat = -1; cbad = 0; lx = -1; ly = -1;
    check("clr_first_x", int'(x), 0);
    check("clr_first_y", int'(y), 0);
    for (int k = 1; k <= 20000; k++) begin
      if (plot) begin
        plots++;
        lx = int'(x);
        ly = int'(y);
        if (colour != 3'd0) cbad++;
      end
      if (done) begin
        lat = k;
        did = int'(done_id);
        break;
      end
      tick();
    end
    check("clr_plots", plots, 19200);
    check("clr_last_x", lx, 159);
    check("clr_last_y", ly, 119);
    check("clr_colour", cbad, 0);
    check("clr_latency", lat, 19201);
    check("clr_done_id", did, 0);
    tick();
    check("clr_then_req0", int'(req_ready), 1);
    req_valid = '0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
